// File: rtl/buck_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | buck_ctrl : PWM controller for a buck stage. Soft-start, integral voltage  |
// |             regulation, cycle-by-cycle current limit and fault auto-retry. |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module buck_ctrl #(
    parameter int PERIOD   = 200,
    parameter int DUTY_MAX = 180,
    parameter int SS_STEP  = 2,
    parameter int WIDTH    = 16,
    parameter int BLANK    = 10,
    parameter int OC_COUNT = 4,
    parameter int RETRY    = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] v_ref,
    input  logic signed [WIDTH-1:0] i_limit,
    input  logic signed [WIDTH-1:0] v_out,
    input  logic signed [WIDTH-1:0] i_mag,
    output logic                    gate,
    output logic [7:0]              duty,
    output logic [1:0]              state,
    output logic                    fault,
    output logic                    sync
);

    localparam int OCW = $clog2(OC_COUNT + 1);
    localparam int RW  = $clog2(RETRY + 1);

    localparam logic [7:0]     C_LAST   = 8'(PERIOD - 1);
    localparam logic [7:0]     C_BLANK  = 8'(BLANK);
    localparam logic [8:0]     C_DMAX   = 9'(DUTY_MAX);
    localparam logic [7:0]     C_DMAX8  = 8'(DUTY_MAX);
    localparam logic [8:0]     C_STEP   = 9'(SS_STEP);
    localparam logic [OCW-1:0] C_OCN    = OCW'(OC_COUNT);
    localparam logic [RW-1:0]  C_RLAST  = RW'(RETRY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOFT  = 2'd1,
        REG   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [7:0]       r_cnt;
    logic [7:0]       r_duty;
    logic [7:0]       w_duty_nx;
    logic [8:0]       w_inc;
    logic [8:0]       w_up;
    logic             r_oc_flag;
    logic             r_sync;
    logic [OCW-1:0]   r_oc_run;
    logic [OCW-1:0]   w_oc_run_nx;
    logic [RW-1:0]    r_retry;
    logic [RW-1:0]    w_retry_nx;
    logic             w_wrap;
    logic             w_active;
    logic             w_gate;
    logic             w_oc_hit;
    logic             w_trip;

    assign w_wrap      = (r_cnt == C_LAST);
    assign w_active    = (r_state == SOFT) || (r_state == REG);
    assign w_gate      = w_active && (r_cnt < r_duty) && !r_oc_flag;
    assign w_oc_hit    = w_gate && (r_cnt >= C_BLANK) && (i_mag > i_limit);
    assign w_oc_run_nx = r_oc_flag ? (r_oc_run + 1'b1) : '0;
    assign w_trip      = w_active && (w_oc_run_nx == C_OCN);
    assign w_inc       = {1'b0, r_duty} + C_STEP;
    assign w_up        = {1'b0, r_duty} + 9'd1;

    // Decision applied at the wrap edge; priority is trip, then disable, then duty update.
    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_retry_nx = r_retry;
        case (r_state)
            IDLE: begin
                w_duty_nx = '0;
                if (en) w_state_nx = SOFT;
            end
            SOFT, REG: begin
                if (w_trip) begin
                    w_state_nx = FAULT;
                    w_duty_nx  = '0;
                    w_retry_nx = '0;
                end else if (!en) begin
                    w_state_nx = IDLE;
                    w_duty_nx  = '0;
                end else if (r_state == SOFT) begin
                    w_duty_nx = (w_inc > C_DMAX) ? C_DMAX8 : w_inc[7:0];
                    if ((v_out >= v_ref) || (r_duty == C_DMAX8)) w_state_nx = REG;
                end else if (v_out < v_ref) begin
                    w_duty_nx = (w_up > C_DMAX) ? C_DMAX8 : w_up[7:0];
                end else if ((v_out > v_ref) && (r_duty != 8'd0)) begin
                    w_duty_nx = r_duty - 8'd1;
                end
            end
            FAULT: begin
                w_duty_nx = '0;
                if (r_retry == C_RLAST) begin
                    w_state_nx = IDLE;
                    w_retry_nx = '0;
                end else begin
                    w_retry_nx = r_retry + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else if (w_wrap) r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sync    <= 1'b0;
            r_duty    <= '0;
            r_oc_flag <= 1'b0;
            r_oc_run  <= '0;
            r_retry   <= '0;
        end else begin
            r_cnt  <= w_wrap ? 8'd0 : (r_cnt + 8'd1);
            r_sync <= w_wrap;
            if (w_wrap) begin
                r_duty    <= w_duty_nx;
                r_oc_flag <= 1'b0;
                r_oc_run  <= (w_state_nx == FAULT) ? '0 : w_oc_run_nx;
                r_retry   <= w_retry_nx;
            end else if (w_oc_hit) begin
                r_oc_flag <= 1'b1;
            end
        end
    end

    assign gate  = w_gate;
    assign duty  = r_duty;
    assign state = r_state;
    assign fault = (r_state == FAULT);
    assign sync  = r_sync;

endmodule
`default_nettype wire

// File: doc/buck_ctrl.md
# buck_ctrl

Digital PWM controller for the buck power stage. It produces the `gate` drive from a free-running switching-period counter and sequences the converter through soft-start into closed-loop voltage regulation. It also provides cycle-by-cycle overcurrent limiting and latches a fault with timed auto-retry. It sits in the testbench between the emulated `buck` model's fixed-point `v_out`/`i_mag` outputs and its `gate` input, replacing the fixed-duty PWM macro.

## Interface
- `PERIOD`, 200: clock cycles per switching period. Legal range 4..255; 200 gives 500 kHz at a 100 MHz `clk`.
- `DUTY_MAX`, 180: upper duty clamp, in counts. Must satisfy `DUTY_MAX` < `PERIOD`.
- `SS_STEP`, 2: duty increment per period during soft-start.
- `WIDTH`, 16: width of `v_out`, `i_mag`, `v_ref` and `i_limit`, signed two's complement, same fixed-point scale as the model.
- `BLANK`, 10: cycles after gate rising during which overcurrent is ignored.
- `OC_COUNT`, 4: consecutive overcurrent periods that trip a fault.
- `RETRY`, 50: periods spent in FAULT before restart.
- Ports:
  - `clk`, input, 1: single clock.
  - `rst`, input, 1: synchronous, active-high reset.
  - `en`, input, 1: run request, level-sensitive.
  - `v_ref`, input, WIDTH: output-voltage target code.
  - `i_limit`, input, WIDTH: inductor-current limit code.
  - `v_out`, input, WIDTH: sampled output voltage.
  - `i_mag`, input, WIDTH: sampled inductor current.
  - `gate`, output, 1: high-side switch drive.
  - `duty`, output, 8: currently applied duty, in counts.
  - `state`, output, 2: IDLE=0, SOFT=1, REG=2, FAULT=3.
  - `fault`, output, 1: high while in FAULT.
  - `sync`, output, 1: one-cycle pulse on the first cycle of each period.

## Operation
- Period counter `cnt` counts 0..`PERIOD`-1 and wraps. It free-runs in every state.
- `gate` = (state is SOFT or REG) AND (`cnt` < `duty`) AND NOT `oc_flag`.
  - It is decoded from flops only. There is no combinational path from any input to `gate`.
- Wrap edge: the clock edge at which `cnt`=`PERIOD`-1. At this edge:
  - `duty` is updated.
  - the state transitions are taken.
  - `oc_flag` is cleared.
  - `v_out` is sampled for the duty decision.
- Duty never changes mid-period.
- IDLE:
  - `duty`=0.
  - At a wrap edge with `en`=1, go to SOFT.
- SOFT:
  - At each wrap edge, `duty` becomes min(`duty`+`SS_STEP`, `DUTY_MAX`).
  - Go to REG at a wrap edge when `v_out` >= `v_ref`, or when `duty` has already reached `DUTY_MAX`.
- REG (integral, one count per period):
  - `v_out` < `v_ref`: `duty`+1.
  - `v_out` > `v_ref`: `duty`-1.
  - Equal: hold.
  - Result is clamped to 0..`DUTY_MAX`.
- `en`=0 in SOFT or REG: at the next wrap edge, go to IDLE with `duty`=0. `gate` finishes the current period normally.
- Overcurrent:
  - Condition: at any edge where `gate`=1, `cnt` >= `BLANK` and `i_mag` > `i_limit` (signed compare), set `oc_flag`.
  - Effect: `gate` falls on the following cycle and stays low for the rest of the period.
  - `oc_run` counts consecutive periods that ended with `oc_flag`=1. A clean period resets `oc_run` to 0.
  - When `oc_run` reaches `OC_COUNT` at a wrap edge, go to FAULT with `duty`=0.
- FAULT:
  - `gate`=0 and `fault`=1.
  - A retry counter counts wrap edges. After `RETRY` of them, go to IDLE; the normal IDLE rule then restarts soft-start if `en`=1.
- `rst` (synchronous, wins over everything, including mid-period):
  - `cnt`=0, state=IDLE, `duty`=0, `gate`=0, `fault`=0, `sync`=0.
  - `oc_flag`, `oc_run` and the retry counter are cleared.
- Arithmetic and clamps:
  - Duty arithmetic is 9-bit, so overflow is impossible before the clamp.
  - A decrement from 0 saturates at 0.
  - `duty`=0 gives no gate pulse in that period.

## Timing
- `sync`=1 exactly on cycles where `cnt`=0. The first pulse comes `PERIOD` cycles after `rst` falls.
- Latencies, all measured from the triggering clock edge:
  - `gate` rises on the cycle `cnt` becomes 0, when `duty`>0.
  - `gate` falls on the cycle `cnt` becomes `duty`.
  - A new `duty` takes effect in the same cycle that `cnt` becomes 0.
  - Overcurrent: one clock from the sampling edge to `gate` low.
- `v_out`/`v_ref`: only the value present at the wrap edge matters. They may change freely in between.
- Simultaneous events at a wrap edge, in priority order: `rst` > OC fault trip > `en`=0 > normal duty/state update.

## Test plan
- `rst` held 3 cycles, `en`=0 → `gate`=0, `duty`=0, `state`=0. `sync` pulses every 200 cycles.
- `en`=1, `v_out`=0, `v_ref`=1000 → `duty` steps 2, 4, 6 … per period up to 180. `gate` is high for exactly `duty` cycles from each `sync`. `state` goes 1 then 2.
- In REG, step `v_out` to 1200 against `v_ref`=1000 → `duty` falls by 1 per period. Equal `v_out`/`v_ref` → `duty` constant.
- `duty`=100, `i_mag` > `i_limit` from `cnt`=5 → no effect until `cnt`=10 (blanking). `gate` low from `cnt`=11 to period end. Next period starts normally.
- Overcurrent in 4 consecutive periods → `fault`=1 and `gate`=0 for 50 periods, then IDLE. Soft-start restarts from `duty`=0.
- Assert `rst` at `cnt`=50 with `gate` high → next cycle `gate`=0, `cnt`=0, `state`=0. `en`=0 mid-period → period completes, then IDLE.
